icache: RTL and testbench
=========================

Name: icache

Overview:
- Read-only, direct-mapped L1 instruction cache. It is the responder to the fetch stage's read request (mem_read1 / resp_a / mem_rdata).
- On a hit it returns the 16-bit instruction word in the same cycle.
- On a miss it fetches a 128-bit line from physical memory through a request/response handshake, fills the line, then answers.
- It sits between the IF stage and the memory arbiter.

Parameters:
- NUM_SETS, 8, number of lines; power of 2; sets index width IDX_W = log2(NUM_SETS).
- LINE_BITS, 128, line width in bits (8 x 16-bit words); fixes offset width at 4 bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  fetch request; held high until mem_resp.
- mem_address  input  16  byte address of the instruction.
- mem_rdata  output  16  instruction word; valid when mem_resp=1.
- mem_resp  output  1  request served this cycle.
- pmem_read  output  1  line read request to memory.
- pmem_address  output  16  line-aligned address; bits [3:0]=0.
- pmem_rdata  input  128  returned line; valid when pmem_resp=1.
- pmem_resp  input  1  memory response; single-cycle pulse.

Behaviour:
- Address split: tag=[15:4+IDX_W], index=[3+IDX_W:4], word=[3:1]. Bit 0 is ignored.
- Storage per set: valid bit, tag, line. Word w of a line occupies line bits [16w+15:16w].
- FSM states: IDLE, FETCH.
- IDLE, hit case: mem_read=1, valid[index]=1 and tag matches.
  - mem_resp=1 and mem_rdata=selected word, combinationally in the same cycle (0-cycle hit).
  - Stay in IDLE.
- IDLE, miss case: mem_read=1 and not hit.
  - mem_resp=0.
  - Latch the line address {mem_address[15:4],4'b0} into miss_addr.
  - Go to FETCH.
- FETCH:
  - pmem_read=1 and pmem_address=miss_addr, held stable until pmem_resp.
  - On pmem_resp=1: write pmem_rdata into the indexed line, set tag, set valid, go to IDLE. pmem_read drops the next cycle.
  - The hit is served from IDLE in the cycle after the fill. Miss latency is (memory latency + 1) cycles to mem_resp.
- mem_resp is never asserted in FETCH. mem_rdata is don't-care when mem_resp=0 but must never be X from an uninitialised array; reset zeroes the lines.
- Request withdrawn mid-miss (mem_read falls in FETCH, e.g. a pipeline redirect): finish the fill, return to IDLE, do not assert mem_resp.
- Address change mid-miss: the fill uses the latched miss_addr. The new address is looked up fresh in IDLE.
- pmem_resp while in IDLE: ignored, no state change.
- Reset at any time:
  - Next edge: state=IDLE, all valid=0, all lines=0.
  - pmem_read=0, mem_resp=0.
  - A pending fill is abandoned. A late pmem_resp after reset is ignored.
- Reset outputs: mem_resp=0, pmem_read=0, pmem_address=0, mem_rdata=0.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each cycle with mem_resp=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- lc3b_types gains:
  - lc3b_c_line (logic [127:0]).
  - lc3b_c_tag (logic [8:0], for the default NUM_SETS).
  - lc3b_c_index (logic [2:0]).
  - lc3b_c_word_sel (logic [2:0]).
- Sub-module icache_array holds valid/tag/data storage: synchronous write port, combinational read, reset clears.
- The icache top holds the FSM, the hit compare and the word mux.

Test Plan:
- Cold miss: after reset, mem_read=1, addr=16'h0012. Required: pmem_read=1 with pmem_address=16'h0010. Memory returns a line whose word1=16'h1234 after 3 cycles. Next cycle mem_resp=1, mem_rdata=16'h1234.
- Hit: immediately after the above, addr=16'h001E. Required: mem_resp=1 the same cycle, mem_rdata=word7 of the same line, pmem_read=0.
- Conflict miss: addr=16'h0090 (same index as 16'h0010, different tag). Required: refill. A re-read of 16'h0012 then misses again.
- Redirect mid-miss: mem_read dropped during FETCH. Required: fill completes, no mem_resp pulse. A later read of that line hits with 0 latency.
- Reset mid-fill: assert reset while pmem_read=1, then send pmem_resp. Required: line not valid. A read of 16'h0012 misses and pmem_read is re-issued.
- Stray response: pulse pmem_resp while in IDLE. Required: no state change, no array write.
- With ICACHE_PERF_EN: after the miss and hit scenarios, miss_count=1 and hit_count=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types for the LC-3b direct-mapped instruction cache.
// Line, tag, index and word-select types for the default 8-set build.
package icache_pkg;

    localparam int LINE_BITS = 128;
    localparam int WORD_BITS = 16;
    localparam int OFFSET_W  = 4;

    typedef logic [127:0] lc3b_c_line;
    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [2:0]   lc3b_c_word_sel;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic {
        S_IDLE,
        S_FETCH
    } icache_state_e;

    // Word w of a line sits at bits [16w+15:16w].
    function automatic lc3b_word line_word(lc3b_c_line l, lc3b_c_word_sel w);
        return l[{w, 4'b0000} +: WORD_BITS];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache.
// Synchronous write, combinational read, reset clears every set.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 12 - IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output lc3b_c_line       rd_line,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  lc3b_c_line       wr_line
);

    logic [NUM_SETS-1:0]                valid_q, valid_d;
    logic [NUM_SETS-1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [NUM_SETS-1:0][LINE_BITS-1:0] data_q, data_d;

    // Read port: lookup of the set addressed by the request.
    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_line  = data_q[rd_idx];
    end

    // Fill port: install a returned line into one set.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_line;
        end
    end

    // Storage registers; reset invalidates and zeroes every line.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped L1 I-cache: 0-cycle hits, line refill on miss.
// Define ICACHE_PERF_EN to add saturating hit/miss counters.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic [15:0]  mem_address,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic [15:0]  pmem_address,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
`ifdef ICACHE_PERF_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 12 - IDX_W;

    icache_state_e    state_q, state_d;
    logic [11:0]      miss_line_q, miss_line_d;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    lc3b_c_word_sel   req_word;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    lc3b_c_line       rd_line;
    logic             hit;
    logic             fill_we;
    logic             miss_start;
    logic             unused_ok;

    assign req_idx   = mem_address[3+IDX_W:4];
    assign req_tag   = mem_address[15:4+IDX_W];
    assign req_word  = mem_address[3:1];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign unused_ok = mem_address[0];

    icache_array #(
        .NUM_SETS (NUM_SETS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (fill_we),
        .wr_idx   (miss_line_q[IDX_W-1:0]),
        .wr_tag   (miss_line_q[11:IDX_W]),
        .wr_line  (pmem_rdata)
    );

    // Next state and outputs; all outputs held low while reset is high.
    always_comb begin
        state_d      = state_q;
        miss_line_d  = miss_line_q;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        fill_we      = 1'b0;
        miss_start   = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (mem_read && hit) begin
                        mem_resp  = 1'b1;
                        mem_rdata = line_word(rd_line, req_word);
                    end else if (mem_read) begin
                        miss_line_d = mem_address[15:4];
                        miss_start  = 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                S_FETCH: begin
                    pmem_read    = 1'b1;
                    pmem_address = {miss_line_q, 4'h0};
                    if (pmem_resp) begin
                        fill_we = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and latched miss line address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            miss_line_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_line_q <= miss_line_d;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    // Saturating counters of served requests and started refills.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (mem_resp && hit_cnt_q != 16'hFFFF)
            hit_cnt_d = hit_cnt_q + 16'd1;
        if (miss_start && miss_cnt_q != 16'hFFFF)
            miss_cnt_d = miss_cnt_q + 16'd1;
    end

    // Counter registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed table, corner sequences, random reads.
// Reference is a tag/valid map plus a flat line memory.
module tb_icache;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_read;
    logic [15:0]  mem_address;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
`ifdef ICACHE_PERF_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    icache dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [127:0] mem [4096];
    bit           mvalid [8];
    logic [8:0]   mtag [8];

    int           lat = 3;
    bit           mem_auto = 1'b1;
    bit           force_resp = 1'b0;
    logic [127:0] force_data = '0;

    typedef struct {
        logic [15:0] addr;
        bit          exp_hit;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [127:0] l;
        l = mem[a[15:4]];
        return l[{a[3:1], 4'b0000} +: 16];
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        return mvalid[a[6:4]] && (mtag[a[6:4]] == a[15:7]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 1'b0;
            mtag[i]   = '0;
        end
    endtask

    task automatic model_fill(input logic [15:0] a);
        mvalid[a[6:4]] = 1'b1;
        mtag[a[6:4]]   = a[15:7];
    endtask

    // Memory responder: pulses pmem_resp after lat cycles of pmem_read.
    initial begin
        int cnt;
        cnt = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (force_resp) begin
                pmem_resp  = 1'b1;
                pmem_rdata = force_data;
                force_resp = 1'b0;
            end else if (pmem_read && mem_auto) begin
                cnt++;
                if (cnt >= lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem[pmem_address[15:4]];
                    cnt = 0;
                end
            end
        end
    end

    task automatic do_read(input logic [15:0] a, input bit exp_hit,
                           input string nm, output logic [15:0] d);
        int cyc;
        bit done;
        bit seen_p;
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = a;
        cyc = 0;
        done = 1'b0;
        seen_p = 1'b0;
        d = '0;
        while (!done && cyc < 20) begin
            #1;
            if (mem_resp) begin
                done = 1'b1;
                d = mem_rdata;
                chk({nm, " pread_at_resp"}, {31'd0, pmem_read}, 32'd0);
            end else begin
                if (pmem_read && !seen_p) begin
                    seen_p = 1'b1;
                    chk({nm, " paddr"}, {16'd0, pmem_address},
                        {16'd0, a[15:4], 4'h0});
                end
                @(negedge clk);
                cyc++;
            end
        end
        mem_read = 1'b0;
        chk({nm, " served"}, {31'd0, done}, 32'd1);
        if (done) begin
            chk({nm, " latency"}, cyc, exp_hit ? 32'd0 : lat + 1);
            chk({nm, " data"}, {16'd0, d}, {16'd0, mem_word(a)});
        end
        model_fill(a);
    endtask

    initial begin
        logic [15:0] d;
        bit seen;

        for (int i = 0; i < 4096; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[1][31:16] = 16'h1234;
        model_clear();

        vecs[0] = '{16'h0012, 1'b0, 16'h1234};
        vecs[1] = '{16'h001E, 1'b1, mem[1][127:112]};
        vecs[2] = '{16'h0090, 1'b0, mem[9][15:0]};
        vecs[3] = '{16'h0012, 1'b0, 16'h1234};
        vecs[4] = '{16'h0014, 1'b1, mem[1][47:32]};

        reset = 1'b1;
        mem_read = 1'b1;
        mem_address = 16'h0012;
        repeat (2) @(negedge clk);
        #1;
        chk("rst mem_resp", {31'd0, mem_resp}, 32'd0);
        chk("rst pmem_read", {31'd0, pmem_read}, 32'd0);
        chk("rst pmem_address", {16'd0, pmem_address}, 32'd0);
        chk("rst mem_rdata", {16'd0, mem_rdata}, 32'd0);
        mem_read = 1'b0;
        reset = 1'b0;

        lat = 3;
        for (int i = 0; i < 5; i++) begin
            do_read(vecs[i].addr, vecs[i].exp_hit, $sformatf("vec%0d", i), d);
            chk($sformatf("vec%0d table_data", i), {16'd0, d},
                {16'd0, vecs[i].exp_data});
`ifdef ICACHE_PERF_EN
            if (i == 1) begin
                @(negedge clk);
                #1;
                chk("perf miss_count", {16'd0, miss_count}, 32'd1);
                chk("perf hit_count", {16'd0, hit_count}, 32'd2);
            end
`endif
        end

        @(negedge clk);
        mem_read = 1'b1;
        mem_address = 16'h0200;
        @(negedge clk);
        #1;
        chk("redir pread", {31'd0, pmem_read}, 32'd1);
        mem_read = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (mem_resp) seen = 1'b1;
        end
        chk("redir no_resp", {31'd0, seen}, 32'd0);
        chk("redir fill_done", {31'd0, pmem_read}, 32'd0);
        model_fill(16'h0200);
        do_read(16'h0202, 1'b1, "redir reread", d);

        do_read(16'h0012, 1'b1, "pre_stray", d);
        @(negedge clk);
        #1;
        force_data = ~mem[1];
        force_resp = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("stray pread", {31'd0, pmem_read}, 32'd0);
        do_read(16'h0012, 1'b1, "stray reread", d);

        mem_auto = 1'b0;
        @(negedge clk);
        mem_read = 1'b1;
        mem_address = 16'h0300;
        @(negedge clk);
        #1;
        chk("rstfill pread", {31'd0, pmem_read}, 32'd1);
        reset = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        chk("rstfill pread_off", {31'd0, pmem_read}, 32'd0);
        chk("rstfill resp_off", {31'd0, mem_resp}, 32'd0);
        reset = 1'b0;
        force_data = mem[12'h030];
        force_resp = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rstfill late_resp", {31'd0, pmem_read}, 32'd0);
        mem_auto = 1'b1;
        model_clear();
        do_read(16'h0302, 1'b0, "rstfill line", d);
        do_read(16'h0012, 1'b0, "rstfill reissue", d);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 16'h03FF));
            lat = $urandom_range(1, 4);
            do_read(a, model_hit(a), $sformatf("rnd%0d", i), d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
